// File: rtl/alu_op_sequencer.sv
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Issue/sequencing controller for the integer ALU operation set.
//                Accepts one operation at a time. Logic and add operations take
//                one cycle. MUL and DIV iterate one bit per cycle. The result
//                and its flags are held until the consumer accepts them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [1:0]       req_type,
    input  logic [3:0]       req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_negative,
    output logic             rsp_zero,
    output logic             rsp_div_by_zero,
    output logic             busy
);

    localparam int               CNT_W      = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [3:0] C_OP_ADD = 4'b0000;
    localparam logic [3:0] C_OP_SUB = 4'b0001;
    localparam logic [3:0] C_OP_MUL = 4'b0010;
    localparam logic [3:0] C_OP_DIV = 4'b0011;
    localparam logic [3:0] C_OP_AND = 4'b0100;
    localparam logic [3:0] C_OP_OR  = 4'b0101;
    localparam logic [3:0] C_OP_XOR = 4'b0110;
    localparam logic [3:0] C_OP_NEG = 4'b0111;
    localparam logic [3:0] C_OP_MOV = 4'b1000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] opa_q,      opa_d;
    logic [WIDTH-1:0] opb_q,      opb_d;
    logic [WIDTH-1:0] acc_q,      acc_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             sign_q,     sign_d;
    logic             is_div_q,   is_div_d;
    logic [WIDTH-1:0] result_q,   result_d;
    logic             negative_q, negative_d;
    logic             zero_q,     zero_d;
    logic             dbz_q,      dbz_d;

    logic             w_dp;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_alu_result;
    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH:0]   w_rem_sub;
    logic [WIDTH-1:0] w_fix_mag;
    logic             w_load;

    assign w_dp     = (req_type == 2'b00);
    assign w_b_zero = (req_b == '0);
    assign w_a_mag  = req_a[WIDTH-1] ? -req_a : req_a;
    assign w_b_mag  = req_b[WIDTH-1] ? -req_b : req_b;

    // DIV only reaches this table when B is zero, hence the all-ones result.
    always_comb begin
        w_alu_result = '0;
        if (!w_dp) begin
            w_alu_result = req_b;
        end else begin
            case (req_op)
                C_OP_ADD: w_alu_result = req_a + req_b;
                C_OP_SUB: w_alu_result = req_a - req_b;
                C_OP_DIV: w_alu_result = '1;
                C_OP_AND: w_alu_result = req_a & req_b;
                C_OP_OR:  w_alu_result = req_a | req_b;
                C_OP_XOR: w_alu_result = req_a ^ req_b;
                C_OP_NEG: w_alu_result = -req_a;
                C_OP_MOV: w_alu_result = req_b;
                default:  w_alu_result = '0;
            endcase
        end
    end

    assign w_rem_shift = {acc_q, opa_q[WIDTH-1]};
    assign w_rem_sub   = w_rem_shift - {1'b0, opb_q};
    assign w_fix_mag   = is_div_q ? opa_q : acc_q;

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        is_div_d = is_div_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        w_load   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    opa_d    = w_a_mag;
                    opb_d    = w_b_mag;
                    acc_d    = '0;
                    cnt_d    = '0;
                    sign_d   = req_a[WIDTH-1] ^ req_b[WIDTH-1];
                    is_div_d = (req_op == C_OP_DIV);
                    if (w_dp && req_op == C_OP_MUL) begin
                        state_d = S_MUL;
                    end else if (w_dp && req_op == C_OP_DIV && !w_b_zero) begin
                        state_d = S_DIV;
                    end else begin
                        result_d = w_alu_result;
                        dbz_d    = w_dp && (req_op == C_OP_DIV);
                        w_load   = 1'b1;
                        state_d  = S_RESP;
                    end
                end
            end
            // Shift-add: opa is the shifting multiplicand, opb the multiplier.
            S_MUL: begin
                if (opb_q[0]) begin
                    acc_d = acc_q + opa_q;
                end
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == C_CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
            // Restoring divide: acc is the remainder, opa shifts dividend out and quotient in.
            S_DIV: begin
                if (!w_rem_sub[WIDTH]) begin
                    acc_d = w_rem_sub[WIDTH-1:0];
                    opa_d = {opa_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = w_rem_shift[WIDTH-1:0];
                    opa_d = {opa_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == C_CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = sign_q ? -w_fix_mag : w_fix_mag;
                dbz_d    = 1'b0;
                w_load   = 1'b1;
                state_d  = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        negative_d = w_load ? result_d[WIDTH-1] : negative_q;
        zero_d     = w_load ? (result_d == '0)  : zero_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            opa_q      <= '0;
            opb_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            is_div_q   <= 1'b0;
            result_q   <= '0;
            negative_q <= 1'b0;
            zero_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            is_div_q   <= is_div_d;
            result_q   <= result_d;
            negative_q <= negative_d;
            zero_q     <= zero_d;
            dbz_q      <= dbz_d;
        end
    end

    assign req_ready       = (state_q == S_IDLE);
    assign busy            = (state_q != S_IDLE);
    assign rsp_valid       = (state_q == S_RESP);
    assign rsp_result      = result_q;
    assign rsp_negative    = negative_q;
    assign rsp_zero        = zero_q;
    assign rsp_div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
//  Module      : tb_alu_op_sequencer
//  Description : Scoreboard bench for alu_op_sequencer (WIDTH = 32).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [1:0]  req_type;
    logic [3:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_negative;
    logic        rsp_zero;
    logic        rsp_div_by_zero;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        logic [31:0] res;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t sb[$];

    alu_op_sequencer #(.WIDTH(32)) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_a           (req_a),
        .req_b           (req_b),
        .req_type        (req_type),
        .req_op          (req_op),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_result      (rsp_result),
        .rsp_negative    (rsp_negative),
        .rsp_zero        (rsp_zero),
        .rsp_div_by_zero (rsp_div_by_zero),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] t, input logic [3:0] op);
        logic [63:0] ma;
        logic [63:0] mb;
        logic [63:0] q;
        logic [31:0] na;
        logic [31:0] nb;
        if (t != 2'b00) return b;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a * b;
            4'd3: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                na = -a;
                nb = -b;
                ma = {32'd0, (a[31] ? na : a)};
                mb = {32'd0, (b[31] ? nb : b)};
                q  = ma / mb;
                return (a[31] ^ b[31]) ? -q[31:0] : q[31:0];
            end
            4'd4: return a & b;
            4'd5: return a | b;
            4'd6: return a ^ b;
            4'd7: return -a;
            4'd8: return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] t,
                         input logic [3:0] op, input int hold);
        exp_t        e;
        exp_t        g;
        int          n;
        logic        busy_ok;
        logic [34:0] snap;
        @(negedge clk);
        chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("idle_req_ready", 64'(req_ready), 64'd1);
        req_a     = a;
        req_b     = b;
        req_type  = t;
        req_op    = op;
        req_valid = 1'b1;
        rsp_ready = (hold == 0);
        e.res = model(a, b, t, op);
        e.dbz = (t == 2'b00) && (op == 4'd3) && (b == 32'd0);
        e.lat = ((t == 2'b00) && ((op == 4'd2) || ((op == 4'd3) && (b != 32'd0)))) ? 34 : 1;
        sb.push_back(e);
        n = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            n++;
            if (!rsp_valid && !busy) busy_ok = 1'b0;
        end while (!rsp_valid && n < 200);
        if (!rsp_valid) begin
            chk("rsp_timeout", 64'd0, 64'd1);
            void'(sb.pop_front());
            return;
        end
        chk("busy_during_op", 64'(busy_ok), 64'd1);
        chk("busy_in_resp", 64'(busy), 64'd1);
        if (sb.size() == 0) begin
            chk("sb_empty", 64'd0, 64'd1);
            return;
        end
        g = sb.pop_front();
        chk("latency", 64'(n), 64'(g.lat));
        chk("result", 64'(rsp_result), 64'(g.res));
        chk("negative", 64'(rsp_negative), 64'(g.res[31]));
        chk("zero", 64'(rsp_zero), 64'(g.res == 32'd0));
        chk("div_by_zero", 64'(rsp_div_by_zero), 64'(g.dbz));
        if (hold > 0) begin
            snap = {rsp_result, rsp_negative, rsp_zero, rsp_div_by_zero};
            for (int k = 0; k < hold; k++) begin
                req_valid = 1'b1;
                req_a     = 32'd77;
                req_b     = 32'd1;
                req_op    = 4'd0;
                @(negedge clk);
                chk("hold_stable", 64'({rsp_result, rsp_negative, rsp_zero, rsp_div_by_zero}), 64'(snap));
                chk("hold_valid", 64'(rsp_valid), 64'd1);
                chk("hold_req_ready", 64'(req_ready), 64'd0);
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            @(negedge clk);
            chk("handoff_busy", 64'(busy), 64'd0);
            chk("handoff_ready", 64'(req_ready), 64'd1);
            chk("handoff_valid", 64'(rsp_valid), 64'd0);
        end
    endtask

    initial begin
        int   n;
        logic seen;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_type  = 2'b00;
        req_op    = 4'd0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_flags", 64'({rsp_result, rsp_negative, rsp_zero, rsp_div_by_zero}), 64'd0);
        rst_n = 1'b1;

        do_op(32'd5, -32'sd5, 2'b00, 4'd0, 0);
        do_op(32'd1, 32'hDEAD_BEEF, 2'b00, 4'd8, 0);

        // Abandon a MUL mid-flight with an asynchronous reset.
        @(negedge clk);
        req_a = -32'sd7; req_b = 32'd6; req_type = 2'b00; req_op = 4'd2; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd1);
        chk("mid_rst_result", 64'(rsp_result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("mid_rst_no_rsp", 64'(seen), 64'd0);

        do_op(-32'sd7, 32'd6, 2'b00, 4'd2, 0);
        do_op(-32'sd7, 32'd2, 2'b00, 4'd3, 0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 4'd3, 0);
        do_op(32'd9, 32'd0, 2'b00, 4'd3, 0);
        do_op(32'hF0F0_1234, 32'h0FF0_FFFF, 2'b00, 4'd4, 0);
        do_op(32'd3, 32'd4, 2'b00, 4'd1, 5);
        do_op(32'h1234_5678, 32'h9ABC_DEF0, 2'b00, 4'd2, 0);
        do_op(32'd100, -32'sd7, 2'b00, 4'd3, 0);
        do_op(32'd5, -32'sd9, 2'b00, 4'd3, 0);
        do_op(32'h8000_0000, 32'd1, 2'b00, 4'd3, 0);
        do_op(32'h0000_00F0, 32'h0000_0F0F, 2'b00, 4'd5, 0);
        do_op(32'hAAAA_5555, 32'hFFFF_0000, 2'b00, 4'd6, 0);
        do_op(32'h8000_0000, 32'd0, 2'b00, 4'd7, 0);
        do_op(32'd11, 32'd22, 2'b00, 4'd15, 0);
        do_op(32'd11, 32'h8765_4321, 2'b01, 4'd2, 0);
        do_op(32'd11, 32'd0, 2'b10, 4'd3, 0);
        for (int i = 0; i < 8; i++) begin
            do_op($urandom, $urandom, (i == 7) ? 2'b11 : 2'b00, 4'($urandom_range(0, 9)), 0);
        end

        n = sb.size();
        chk("sb_drained", 64'(n), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
